// File: rtl/controle_deslocamento_pkg.sv
// Shared constants for the multi-cycle left shift/rotate sequencer:
// data/amount widths and FSM state encodings.
package controle_deslocamento_pkg;

   localparam int unsigned LARGURA  = 16;
   localparam int unsigned LARG_QTD = 4;

   localparam logic [1:0] S_OCIOSO  = 2'd0;
   localparam logic [1:0] S_DESLOCA = 2'd1;
   localparam logic [1:0] S_FIM     = 2'd2;

endpackage

// File: rtl/controle_deslocamento_desloca_esq16.sv
// Fixed 16-bit, 1-position left shifter (DeslocaEsq16 datapath).
// The bit leaving position 15 is exported for overflow/rotate use.
module desloca_esq16
   import controle_deslocamento_pkg::*;
(
   input  logic [LARGURA-1:0] a,
   output logic [LARGURA-1:0] y,
   output logic               saida
);

   assign y     = {a[LARGURA-2:0], 1'b0};
   assign saida = a[LARGURA-1];

endmodule

// File: rtl/controle_deslocamento.sv
// Sequencer applying the 1-bit left shifter once per clock to perform a
// 0..15 position logical shift or rotate over a start/pronto/valido handshake.
module controle_deslocamento
   import controle_deslocamento_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                modo,
   input  logic [LARGURA-1:0]  dado_in,
   input  logic [LARG_QTD-1:0] qtd,
   output logic                pronto,
   output logic                ocupado,
   output logic                valido,
   output logic [LARGURA-1:0]  resultado,
   output logic                estouro
);

   logic [1:0]          estado;
   logic [1:0]          estado_prox;
   logic [LARGURA-1:0]  reg_dado;
   logic [LARGURA-1:0]  reg_dado_prox;
   logic [LARG_QTD-1:0] cnt;
   logic [LARG_QTD-1:0] cnt_prox;
   logic                reg_modo;
   logic                reg_modo_prox;
   logic                estouro_prox;
   logic                pronto_prox;
   logic                ocupado_prox;
   logic                valido_prox;
   logic [LARGURA-1:0]  desl_y;
   logic                desl_saida;

   desloca_esq16 u_desloca (
      .a     (reg_dado),
      .y     (desl_y),
      .saida (desl_saida)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         estado <= S_OCIOSO;
      end else begin
         estado <= estado_prox;
      end
   end

   // Next state, datapath update and registered-output precomputation
   always_comb begin
      estado_prox   = estado;
      reg_dado_prox = reg_dado;
      cnt_prox      = cnt;
      reg_modo_prox = reg_modo;
      estouro_prox  = estouro;

      case (estado)
         S_OCIOSO: begin
            if (start) begin
               reg_dado_prox = dado_in;
               cnt_prox      = qtd;
               reg_modo_prox = modo;
               estouro_prox  = 1'b0;
               estado_prox   = (qtd != '0) ? S_DESLOCA : S_FIM;
            end
         end
         S_DESLOCA: begin
            // Rotate fill: the bit shifted out re-enters at bit 0
            reg_dado_prox = {desl_y[LARGURA-1:1], desl_y[0] | (reg_modo & desl_saida)};
            if (!reg_modo) begin
               estouro_prox = estouro | desl_saida;
            end
            cnt_prox = cnt - LARG_QTD'(1);
            if (cnt <= LARG_QTD'(1)) begin
               estado_prox = S_FIM;
            end
         end
         S_FIM: begin
            estado_prox = S_OCIOSO;
         end
         default: begin
            estado_prox = S_OCIOSO;
         end
      endcase

      pronto_prox  = (estado_prox == S_OCIOSO);
      ocupado_prox = (estado_prox == S_DESLOCA) || (estado_prox == S_FIM);
      valido_prox  = (estado_prox == S_FIM);
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         reg_dado <= '0;
         cnt      <= '0;
         reg_modo <= 1'b0;
         estouro  <= 1'b0;
         pronto   <= 1'b1;
         ocupado  <= 1'b0;
         valido   <= 1'b0;
      end else begin
         reg_dado <= reg_dado_prox;
         cnt      <= cnt_prox;
         reg_modo <= reg_modo_prox;
         estouro  <= estouro_prox;
         pronto   <= pronto_prox;
         ocupado  <= ocupado_prox;
         valido   <= valido_prox;
      end
   end

   assign resultado = reg_dado;

endmodule

// File: tb/tb_controle_deslocamento.sv
// Scoreboard bench for controle_deslocamento: directed cases plus random
// operations, checked against an arithmetic shift/rotate reference model.
module tb_controle_deslocamento;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        modo;
   logic [15:0] dado_in;
   logic [3:0]  qtd;
   logic        pronto;
   logic        ocupado;
   logic        valido;
   logic [15:0] resultado;
   logic        estouro;

   typedef struct {
      logic [15:0] res;
      logic        est;
      int          ciclo;
   } esperado_t;

   esperado_t fila[$];
   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   controle_deslocamento dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .modo      (modo),
      .dado_in   (dado_in),
      .qtd       (qtd),
      .pronto    (pronto),
      .ocupado   (ocupado),
      .valido    (valido),
      .resultado (resultado),
      .estouro   (estouro)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nome, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, act, exp, cyc);
      end
   endtask

   // Reference: shift/rotate computed over a 32-bit window
   function automatic void modelo(input logic [15:0] d, input int n, input logic m,
                                  output logic [15:0] r, output logic e);
      logic [31:0] larga;
      larga = {16'h0000, d} << n;
      if (m) begin
         r = larga[15:0] | larga[31:16];
         e = 1'b0;
      end else begin
         r = larga[15:0];
         e = (larga[31:16] != 16'h0000);
      end
   endfunction

   // Monitor: every valido pulse must match the oldest expected result
   always @(negedge clk) begin
      if (!rst && valido) begin
         if (fila.size() == 0) begin
            chk("valido_inesperado", 1, 0);
         end else begin
            esperado_t x;
            x = fila.pop_front();
            chk("resultado", int'(resultado), int'(x.res));
            chk("estouro", int'(estouro), int'(x.est));
            chk("latencia", cyc, x.ciclo);
         end
      end
   end

   // Issue one op at the next negedge, then keep DUT busy-side inputs noisy
   task automatic operar(input logic [15:0] d, input logic [3:0] n, input logic m);
      logic [15:0] r;
      logic        e;
      int          k;
      esperado_t   x;
      @(negedge clk);
      chk("pronto_antes", int'(pronto), 1);
      chk("ocupado_antes", int'(ocupado), 0);
      start   = 1'b1;
      dado_in = d;
      qtd     = n;
      modo    = m;
      @(posedge clk);
      #1;
      k = cyc;
      modelo(d, int'(n), m, r, e);
      x.res   = r;
      x.est   = e;
      x.ciclo = k + int'(n);
      fila.push_back(x);
      for (int i = 0; i <= int'(n); i++) begin
         @(negedge clk);
         chk("ocupado_durante", int'(ocupado), 1);
         chk("pronto_durante", int'(pronto), 0);
         start   = 1'($urandom_range(0, 1));
         dado_in = 16'($urandom);
         qtd     = 4'($urandom);
         modo    = 1'($urandom_range(0, 1));
      end
      start = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      modo    = 1'b0;
      dado_in = 16'h0;
      qtd     = 4'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_resultado", int'(resultado), 0);
      chk("rst_pronto", int'(pronto), 1);
      chk("rst_ocupado", int'(ocupado), 0);
      chk("rst_valido", int'(valido), 0);
      chk("rst_estouro", int'(estouro), 0);
      rst = 1'b0;

      operar(16'h0001, 4'd4, 1'b0);
      operar(16'hC003, 4'd2, 1'b0);
      operar(16'h8001, 4'd15, 1'b1);
      operar(16'hABCD, 4'd0, 1'b0);
      operar(16'hFFFF, 4'd15, 1'b0);
      operar(16'h8000, 4'd1, 1'b1);

      for (int i = 0; i < 40; i++) begin
         operar(16'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
      end

      // Abort mid-operation: no valido, outputs back to reset values
      @(negedge clk);
      start   = 1'b1;
      dado_in = 16'h00FF;
      qtd     = 4'd8;
      modo    = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_valido", int'(valido), 0);
      chk("abort_resultado", int'(resultado), 0);
      chk("abort_pronto", int'(pronto), 1);
      chk("abort_ocupado", int'(ocupado), 0);
      chk("abort_estouro", int'(estouro), 0);
      repeat (12) @(negedge clk);
      chk("abort_sem_valido", int'(valido), 0);

      operar(16'h1234, 4'd3, 1'b1);
      repeat (3) @(negedge clk);
      chk("fila_vazia", fila.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
